// File: rtl/router_pkg.sv
// Shared types and defaults for the packet router output side.
package router_pkg;

    localparam int NUM_CH            = 3;
    localparam int DEFAULT_TIMEOUT   = 30;
    localparam int DEFAULT_MAX_BURST = 4;

    typedef logic [1:0] chan_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } sched_state_t;

    // Round-robin successor over the three channels (2 wraps to 0).
    function automatic chan_t next_chan(input chan_t c);
        return (c == chan_t'(NUM_CH - 1)) ? chan_t'(0) : c + chan_t'(1);
    endfunction

endpackage

// File: rtl/router_ch_timer.sv
// Per-channel starvation timer: counts cycles a channel holds data unserviced
// and emits a one-cycle soft_reset pulse when the count reaches TIMEOUT.
module router_ch_timer
    import router_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic resetn,
    input  logic vld,
    input  logic popped,
    input  logic granted,
    output logic fire_next,
    output logic soft_reset
);

    logic [7:0] timer_reg;
    logic       soft_reset_reg;
    logic       waiting;

    assign waiting = vld && !popped && !granted;

    // A pop only ever happens on the granted channel, so the fire term can
    // leave out popped; this keeps read_enb -> fire_next -> read_enb acyclic.
    assign fire_next  = vld && !granted && (timer_reg == 8'(TIMEOUT - 1));
    assign soft_reset = soft_reset_reg;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            timer_reg      <= '0;
            soft_reset_reg <= 1'b0;
        end else begin
            soft_reset_reg <= fire_next;
            if (waiting && !fire_next) begin
                timer_reg <= timer_reg + 8'd1;
            end else begin
                timer_reg <= '0;
            end
        end
    end

endmodule

// File: rtl/router_drain_scheduler.sv
// Drains the router's three channel FIFOs onto one 8-bit stream with
// round-robin bounded-burst arbitration and per-channel starvation flushes.
module router_drain_scheduler
    import router_pkg::*;
#(
    parameter int NUM_CH    = 3,
    parameter int MAX_BURST = DEFAULT_MAX_BURST,
    parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [2:0] vldout,
    input  logic [7:0] data_in_0,
    input  logic [7:0] data_in_1,
    input  logic [7:0] data_in_2,
    output logic [2:0] read_enb,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_chan,
    output logic [2:0] soft_reset,
    output logic       grant_active
);

    sched_state_t state_reg;
    chan_t        gnt_reg;
    chan_t        rr_ptr_reg;
    logic [3:0]   burst_cnt_reg;
    logic [7:0]   out_data_reg;
    chan_t        out_chan_reg;
    logic         out_valid_reg;

    logic [2:0]   fire_next;
    logic [2:0]   granted_vec;
    logic [7:0]   head_data;
    logic         can_pop;
    logic         release_now;
    logic         found;
    chan_t        pick;
    chan_t        cand1;
    chan_t        cand2;

    assign out_data     = out_data_reg;
    assign out_chan     = out_chan_reg;
    assign out_valid    = out_valid_reg;
    assign grant_active = (state_reg == GRANT);

    always_comb begin
        case (gnt_reg)
            2'd0:    head_data = data_in_0;
            2'd1:    head_data = data_in_1;
            default: head_data = data_in_2;
        endcase
    end

    assign can_pop = (state_reg == GRANT) && vldout[gnt_reg]
                     && (!out_valid_reg || out_ready) && !fire_next[gnt_reg];

    assign release_now = (state_reg == GRANT)
                         && ((can_pop && (burst_cnt_reg + 4'd1 == 4'(MAX_BURST)))
                             || !vldout[gnt_reg] || fire_next[gnt_reg]);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign read_enb[gi]    = can_pop && (gnt_reg == chan_t'(gi));
            assign granted_vec[gi] = (state_reg == GRANT) && (gnt_reg == chan_t'(gi));

            router_ch_timer #(
                .TIMEOUT(TIMEOUT)
            ) u_timer (
                .clk        (clk),
                .resetn     (resetn),
                .vld        (vldout[gi]),
                .popped     (read_enb[gi]),
                .granted    (granted_vec[gi]),
                .fire_next  (fire_next[gi]),
                .soft_reset (soft_reset[gi])
            );
        end
    endgenerate

    // Search order starts at rr_ptr and walks upward with wrap.
    assign cand1 = next_chan(rr_ptr_reg);
    assign cand2 = next_chan(cand1);

    always_comb begin
        found = 1'b1;
        pick  = rr_ptr_reg;
        if (vldout[rr_ptr_reg]) begin
            pick = rr_ptr_reg;
        end else if (vldout[cand1]) begin
            pick = cand1;
        end else if (vldout[cand2]) begin
            pick = cand2;
        end else begin
            found = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg     <= IDLE;
            gnt_reg       <= '0;
            rr_ptr_reg    <= '0;
            burst_cnt_reg <= '0;
            out_data_reg  <= '0;
            out_chan_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            if (can_pop) begin
                out_data_reg  <= head_data;
                out_chan_reg  <= gnt_reg;
                out_valid_reg <= 1'b1;
            end else if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (found) begin
                        state_reg     <= GRANT;
                        gnt_reg       <= pick;
                        burst_cnt_reg <= '0;
                    end
                end
                GRANT: begin
                    if (can_pop) begin
                        burst_cnt_reg <= burst_cnt_reg + 4'd1;
                    end
                    if (release_now) begin
                        state_reg  <= IDLE;
                        rr_ptr_reg <= next_chan(gnt_reg);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_router_drain_scheduler.sv
// Directed bench: two scheduler instances (MAX_BURST 4 and 2) fed by queue
// models of the router FIFOs, checked with immediate assertions.
module tb_router_drain_scheduler;

    logic       clk = 1'b0;
    logic       resetn;
    logic [2:0] vld    [2];
    logic [7:0] din    [2][3];
    logic [2:0] re     [2];
    logic [7:0] odata  [2];
    logic       ovalid [2];
    logic       ordy   [2];
    logic [1:0] ochan  [2];
    logic [2:0] srst   [2];
    logic       gact   [2];

    logic [7:0] q [6][$];

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    router_drain_scheduler #(.NUM_CH(3), .MAX_BURST(4), .TIMEOUT(30)) dut_a (
        .clk(clk), .resetn(resetn), .vldout(vld[0]),
        .data_in_0(din[0][0]), .data_in_1(din[0][1]), .data_in_2(din[0][2]),
        .read_enb(re[0]), .out_data(odata[0]), .out_valid(ovalid[0]),
        .out_ready(ordy[0]), .out_chan(ochan[0]), .soft_reset(srst[0]),
        .grant_active(gact[0])
    );

    router_drain_scheduler #(.NUM_CH(3), .MAX_BURST(2), .TIMEOUT(30)) dut_b (
        .clk(clk), .resetn(resetn), .vldout(vld[1]),
        .data_in_0(din[1][0]), .data_in_1(din[1][1]), .data_in_2(din[1][2]),
        .read_enb(re[1]), .out_data(odata[1]), .out_valid(ovalid[1]),
        .out_ready(ordy[1]), .out_chan(ochan[1]), .soft_reset(srst[1]),
        .grant_active(gact[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic refresh();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 3; c++) begin
                vld[d][c] = (q[d*3+c].size() != 0);
                din[d][c] = (q[d*3+c].size() != 0) ? q[d*3+c][0] : 8'h00;
            end
        end
    endtask

    task automatic push(input int d, input int c, input logic [7:0] v);
        q[d*3+c].push_back(v);
    endtask

    // One clock: pop what the DUTs requested, apply flush pulses, settle.
    task automatic step();
        logic [2:0] re_s [2];
        re_s[0] = re[0];
        re_s[1] = re[1];
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 3; c++) begin
                if (re_s[d][c] && q[d*3+c].size() != 0) void'(q[d*3+c].pop_front());
                if (srst[d][c]) q[d*3+c].delete();
            end
        end
        refresh();
        #1;
    endtask

    task automatic do_reset();
        for (int i = 0; i < 6; i++) q[i].delete();
        refresh();
        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
        #1;
    endtask

    initial begin
        logic [7:0] t1_exp [3];
        int         j;
        logic       exp_v;
        logic [7:0] exp_d;

        t1_exp[0] = 8'h11;
        t1_exp[1] = 8'h22;
        t1_exp[2] = 8'h33;
        ordy[0]   = 1'b1;
        ordy[1]   = 1'b1;
        resetn    = 1'b0;
        refresh();

        // Reset state
        do_reset();
        check("rst_valid", 32'(ovalid[0]), 32'h0);
        check("rst_data",  32'(odata[0]),  32'h0);
        check("rst_chan",  32'(ochan[0]),  32'h0);
        check("rst_soft",  32'(srst[0]),   32'h0);
        check("rst_gact",  32'(gact[0]),   32'h0);
        check("rst_re",    32'(re[0]),     32'h0);
        check("rst_valid_b", 32'(ovalid[1]), 32'h0);

        // Single channel drain
        push(0, 0, 8'h11); push(0, 0, 8'h22); push(0, 0, 8'h33);
        refresh(); #1;
        check("t1_idle_re", 32'(re[0]), 32'h0);
        step();
        check("t1_gact", 32'(gact[0]), 32'h1);
        check("t1_re_first", 32'(re[0]), 32'b001);
        for (int i = 0; i < 3; i++) begin
            step();
            $display("t1 byte %0d chan=%0d data=%02h", i, ochan[0], odata[0]);
            check("t1_data",  32'(odata[0]),  32'(t1_exp[i]));
            check("t1_chan",  32'(ochan[0]),  32'h0);
            check("t1_valid", 32'(ovalid[0]), 32'h1);
            check("t1_re",    32'(re[0]),     (i < 2) ? 32'b001 : 32'b000);
        end
        step();
        check("t1_release", 32'(gact[0]),  32'h0);
        check("t1_drained", 32'(ovalid[0]), 32'h0);

        // Round-robin, MAX_BURST=2
        do_reset();
        for (int c = 0; c < 3; c++)
            for (int k = 0; k < 4; k++) push(1, c, 8'(c*16 + k));
        refresh(); #1;
        j = 0;
        for (int s = 1; s <= 18; s++) begin
            step();
            exp_v = (s % 3 != 1);
            check("t2_valid", 32'(ovalid[1]), 32'(exp_v));
            if (exp_v) begin
                exp_d = 8'(((j/2) % 3) * 16 + (j/6) * 2 + (j % 2));
                $display("t2 byte %0d chan=%0d data=%02h", j, ochan[1], odata[1]);
                check("t2_chan", 32'(ochan[1]), 32'((j/2) % 3));
                check("t2_data", 32'(odata[1]), 32'(exp_d));
                j++;
            end
        end

        // Backpressure
        do_reset();
        push(0, 0, 8'hA5); push(0, 0, 8'hB6); push(0, 0, 8'hC7);
        refresh(); #1;
        step();
        step();
        check("t3_first", 32'(odata[0]), 32'hA5);
        ordy[0] = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t3_hold_data",  32'(odata[0]),  32'hA5);
            check("t3_hold_valid", 32'(ovalid[0]), 32'h1);
            check("t3_hold_re",    32'(re[0]),     32'h0);
            check("t3_hold_soft",  32'(srst[0]),   32'h0);
        end
        ordy[0] = 1'b1;
        #1;
        check("t3_resume_re", 32'(re[0]), 32'b001);
        step();
        $display("t3 byte chan=%0d data=%02h", ochan[0], odata[0]);
        check("t3_second", 32'(odata[0]), 32'hB6);
        step();
        $display("t3 byte chan=%0d data=%02h", ochan[0], odata[0]);
        check("t3_third", 32'(odata[0]), 32'hC7);

        // Timeout on a starved channel while ch0 is stalled
        do_reset();
        ordy[0] = 1'b0;
        push(0, 0, 8'h01); push(0, 0, 8'h02); push(0, 0, 8'h03);
        refresh(); #1;
        step();
        step();
        push(0, 1, 8'h44);
        refresh(); #1;
        for (int s = 1; s <= 31; s++) begin
            step();
            check("t4_soft", 32'(srst[0]), (s == 30) ? 32'b010 : 32'b000);
        end
        check("t4_gact", 32'(gact[0]), 32'h1);
        ordy[0] = 1'b1;

        // Reset in the middle of a ch2 burst
        do_reset();
        push(0, 2, 8'hC0); push(0, 2, 8'hC1); push(0, 2, 8'hC2); push(0, 2, 8'hC3);
        refresh(); #1;
        step();
        step();
        step();
        check("t5_pre_chan", 32'(ochan[0]), 32'h2);
        check("t5_pre_data", 32'(odata[0]), 32'hC1);
        resetn = 1'b0;
        #1;
        step();
        check("t5_valid", 32'(ovalid[0]), 32'h0);
        check("t5_re",    32'(re[0]),     32'h0);
        check("t5_soft",  32'(srst[0]),   32'h0);
        check("t5_gact",  32'(gact[0]),   32'h0);
        resetn = 1'b1;
        push(0, 0, 8'h0A);
        refresh(); #1;
        check("t5_idle_re", 32'(vld[0]), 32'b101);
        check("t5_no_pop",  32'(re[0]),   32'h0);
        step();
        check("t5_grant_re", 32'(re[0]), 32'b001);
        step();
        $display("t5 byte chan=%0d data=%02h", ochan[0], odata[0]);
        check("t5_chan", 32'(ochan[0]), 32'h0);
        check("t5_data", 32'(odata[0]), 32'h0A);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/router_drain_scheduler.md
Name: router_drain_scheduler

Overview:
- Output-side scheduler for the 3-channel packet router. Drains the router's per-channel FIFOs onto one shared 8-bit output stream.
- Arbitrates round-robin with a bounded burst per grant and drives the router's read enables.
- Watches each channel for unserviced data and raises a per-channel soft_reset pulse when a channel waits longer than TIMEOUT cycles.
- Sits between router_ultra_compact (vldout/data_out_N/read_enb) and the chip output pins.

Parameters:
- NUM_CH, 3, number of router channels; only 3 supported.
- MAX_BURST, 4, maximum bytes popped per grant before rotating (1..15).
- TIMEOUT, 30, cycles a non-granted channel may hold vldout high unread before soft_reset fires (2..255).

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- vldout  in  3  per-channel FIFO non-empty from router.
- data_in_0  in  8  channel 0 FIFO head (first-word-fall-through).
- data_in_1  in  8  channel 1 FIFO head.
- data_in_2  in  8  channel 2 FIFO head.
- read_enb  out  3  per-channel pop to router; combinational, at most one bit high.
- out_data  out  8  registered output byte.
- out_valid  out  1  out_data holds a byte.
- out_ready  in  1  downstream accepts out_data this cycle.
- out_chan  out  2  channel id of the byte in out_data.
- soft_reset  out  3  one-cycle per-channel flush pulse to router.
- grant_active  out  1  high while the scheduler is in GRANT.

Behaviour:
- Reset is checked on the clk edge while resetn=0; it overrides everything, including mid-burst:
  - state=IDLE, rr_ptr=0, burst_cnt=0, all timers=0.
  - out_valid=0, out_data=0, out_chan=0, soft_reset=0, grant_active=0.
  - read_enb=0 combinationally while in IDLE.
- States:
  - IDLE: find the first n with vldout[n]=1, searching from rr_ptr upward and wrapping 2->0. If found, go to GRANT with gnt=n and burst_cnt=0. Otherwise stay in IDLE. No pop happens in IDLE.
  - GRANT: can_pop = vldout[gnt] && (!out_valid || out_ready) && !soft_reset_next[gnt].
    - read_enb[gnt]=can_pop, same cycle.
    - On can_pop: out_data<=data_in_gnt, out_chan<=gnt, out_valid<=1, burst_cnt++.
    - If out_valid && out_ready && !can_pop: out_valid<=0.
- Release from GRANT to IDLE happens when any of the following holds:
  - can_pop and burst_cnt+1==MAX_BURST;
  - vldout[gnt]=0;
  - soft_reset fires for gnt.
- On release, rr_ptr<=(gnt+1) mod 3 (2 wraps to 0).
- Latency: a byte appears on out_data one cycle after its read_enb.
- Throughput: one byte per cycle within a burst when out_ready=1.
- Each grant costs one IDLE arbitration cycle.
- Backpressure: while out_valid=1 and out_ready=0, out_data and out_chan are held stable and read_enb=0.
- Timers, per channel n:
  - Increment when vldout[n]=1 && read_enb[n]=0 && !(GRANT && gnt==n).
  - Otherwise clear to 0.
  - A granted channel stalled by out_ready never times out.
  - soft_reset_next[n] is asserted when timer==TIMEOUT-1 and incrementing.
  - soft_reset[n] is registered, so it is high for exactly one cycle. The timer clears in the same cycle.
  - soft_reset_next suppresses read_enb[n] that cycle.
- Several timers may fire in the same cycle; each pulses independently.
- Width rules:
  - Timers are 8-bit.
  - burst_cnt is 4-bit and compared to MAX_BURST zero-extended.
  - rr_ptr is 2-bit; value 3 never occurs.
- vldout[3:...] patterns with unused channels are ignored. A channel that drops vldout mid-grant is released without error.

Decomposition:
- Shared package router_pkg:
  - NUM_CH=3;
  - chan_t (2-bit channel id);
  - sched_state_t {IDLE, GRANT};
  - DEFAULT_TIMEOUT=30;
  - DEFAULT_MAX_BURST=4.
- One sub-module router_ch_timer (TIMEOUT param; inputs vld, popped, granted; outputs fire_next, soft_reset), instantiated 3 times.
- Arbiter, FSM and output register stay in router_drain_scheduler.

Test Plan:
- Single channel: ch0 holds 0x11,0x22,0x33, out_ready=1.
  - Expect read_enb=001 for 3 consecutive cycles.
  - Expect out_data 0x11,0x22,0x33 each one cycle later, out_chan=0, then return to IDLE.
- Round-robin with MAX_BURST=2: all channels hold 4 bytes, out_ready=1.
  - Expect out_chan sequence 0,0,1,1,2,2,0,0,1,1,2,2.
  - Expect one idle cycle between bursts and rr_ptr wrapping 2->0.
- Backpressure: out_ready=0 for 5 cycles after the first byte (0xA5).
  - Expect out_data=0xA5 held, read_enb=000, no soft_reset.
  - Expect draining to resume the cycle after out_ready=1.
- Timeout: ch0 granted, out_ready=0, vldout=011 held.
  - Expect soft_reset=010 for exactly one cycle, 30 cycles after vldout[1] rose.
  - Expect soft_reset[0] never asserted.
- Reset mid-burst: resetn=0 for one cycle during a ch2 burst.
  - Expect out_valid=0, read_enb=000, soft_reset=000 next cycle, rr_ptr=0.
  - Expect the next grant to go to ch0 when vldout=101.
